// File: rtl/id_ex_pipe_reg_pkg.sv
// id_ex_pipe_reg_pkg: shared encodings and control-bundle layout for the ID/EX pipeline register.
package id_ex_pipe_reg_pkg;
  localparam int EX_CMD_W = 4;
  localparam int SHIFT_OP_W = 12;
  localparam int IMM24_W = 24;
  typedef enum logic [EX_CMD_W-1:0] {
    EX_NOP = 4'h0,
    EX_MOV = 4'h1,
    EX_ADD = 4'h2,
    EX_ADC = 4'h3,
    EX_SUB = 4'h4,
    EX_SBC = 4'h5,
    EX_AND = 4'h6,
    EX_ORR = 4'h7,
    EX_EOR = 4'h8,
    EX_MVN = 4'h9,
    EX_CMP = 4'hA,
    EX_TST = 4'hB,
    EX_LDR = 4'hC,
    EX_STR = 4'hD
  } ex_cmd_e;
  localparam logic [1:0] MODE_ARITH = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  // valid rides with the control bits so bubbles and flushes clear it together
  typedef struct packed {
    ex_cmd_e ex_cmd;
    logic mem_read;
    logic mem_write;
    logic wb_en;
    logic b;
    logic s;
    logic valid;
  } ctrl_t;
  localparam int CTRL_W = $bits(ctrl_t);
endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: decode-side inputs and execute-side outputs of the ID/EX register.
interface id_ex_pipe_reg_if #(parameter int DATA_W = 32, parameter int REG_W = 4, parameter int CNT_W = 16);
  import id_ex_pipe_reg_pkg::*;
  logic freeze, flush, bubble_in;
  logic [DATA_W-1:0] pc_in, val_rn_in, val_rm_in, pc_out, val_rn_out, val_rm_out;
  logic [EX_CMD_W-1:0] ex_cmd_in, ex_cmd_out;
  logic mem_read_in, mem_write_in, wb_en_in, b_in, s_in, imm_in;
  logic mem_read_out, mem_write_out, wb_en_out, b_out, s_out, imm_out;
  logic [SHIFT_OP_W-1:0] shift_op_in, shift_op_out;
  logic [IMM24_W-1:0] imm24_in, imm24_out;
  logic [REG_W-1:0] dest_in, src1_in, src2_in, dest_out, src1_out, src2_out;
  logic valid_out;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;
  modport master (
    output freeze, flush, bubble_in, pc_in, ex_cmd_in, mem_read_in, mem_write_in, wb_en_in, b_in, s_in,
           imm_in, val_rn_in, val_rm_in, shift_op_in, imm24_in, dest_in, src1_in, src2_in,
    input  pc_out, ex_cmd_out, mem_read_out, mem_write_out, wb_en_out, b_out, s_out, imm_out,
           val_rn_out, val_rm_out, shift_op_out, imm24_out, dest_out, src1_out, src2_out,
           valid_out, bubble_cnt, flush_cnt
  );
  modport slave (
    input  freeze, flush, bubble_in, pc_in, ex_cmd_in, mem_read_in, mem_write_in, wb_en_in, b_in, s_in,
           imm_in, val_rn_in, val_rm_in, shift_op_in, imm24_in, dest_in, src1_in, src2_in,
    output pc_out, ex_cmd_out, mem_read_out, mem_write_out, wb_en_out, b_out, s_out, imm_out,
           val_rn_out, val_rm_out, shift_op_out, imm24_out, dest_out, src1_out, src2_out,
           valid_out, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg_pipe_field_reg.sv
// pipe_field_reg: register slice with clear (to clear_value_i) over hold over load.
module pipe_field_reg #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         hold_i,
  input  logic [W-1:0] clear_value_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = clear_i ? clear_value_i : hold_i ? q_q : d_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with freeze, flush, bubble insertion and perf counters.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  id_ex_pipe_reg_if.slave p
);
  localparam int DATA_BW = 3 * DATA_W + SHIFT_OP_W + IMM24_W + 3 * REG_W + 1;
  ctrl_t ctrl_d, ctrl_q;
  logic [CTRL_W-1:0] ctrl_raw_q;
  logic [DATA_BW-1:0] data_d, data_q;
  logic bubble_take;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;
  assign ctrl_d = '{ex_cmd: ex_cmd_e'(p.ex_cmd_in), mem_read: p.mem_read_in, mem_write: p.mem_write_in,
                    wb_en: p.wb_en_in, b: p.b_in, s: p.s_in, valid: 1'b1};
  assign data_d = {p.pc_in, p.val_rn_in, p.val_rm_in, p.shift_op_in, p.imm24_in,
                   p.dest_in, p.src1_in, p.src2_in, p.imm_in};
  // a bubble zeroes only the control slice; operands still load for forwarding compares
  pipe_field_reg #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .rst(rst), .clear_i(p.flush | (p.bubble_in & ~p.freeze)), .hold_i(p.freeze),
    .clear_value_i('0), .d_i(ctrl_d), .q_o(ctrl_raw_q)
  );
  pipe_field_reg #(.W(DATA_BW)) u_data (
    .clk(clk), .rst(rst), .clear_i(p.flush), .hold_i(p.freeze),
    .clear_value_i('0), .d_i(data_d), .q_o(data_q)
  );
  assign ctrl_q = ctrl_t'(ctrl_raw_q);
  assign p.ex_cmd_out = ctrl_q.ex_cmd;
  assign p.mem_read_out = ctrl_q.mem_read;
  assign p.mem_write_out = ctrl_q.mem_write;
  assign p.wb_en_out = ctrl_q.wb_en;
  assign p.b_out = ctrl_q.b;
  assign p.s_out = ctrl_q.s;
  assign p.valid_out = ctrl_q.valid;
  assign {p.pc_out, p.val_rn_out, p.val_rm_out, p.shift_op_out, p.imm24_out,
          p.dest_out, p.src1_out, p.src2_out, p.imm_out} = data_q;
  assign bubble_take = p.bubble_in & ~p.flush & ~p.freeze;
  assign bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, bubble_take & ~&bubble_cnt_q};
  assign flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, p.flush & ~&flush_cnt_q};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  assign p.bubble_cnt = bubble_cnt_q;
  assign p.flush_cnt = flush_cnt_q;
endmodule
